// File: rtl/fmul_arb_if.sv
// fmul_arb_if: bundles the operation request, result return and fmul
// connections of the fmul arbiter.
//   req0_* / req1_* : operation requests (valid/ready with two operands)
//   res0_* / res1_* : per-requester result streams (valid/ready, product, ovf)
//   fm_*            : operands out to, and product/overflow back from, the fmul
// The slave modport is the arbiter's side; master is the requester/fmul side.
interface fmul_arb_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_x1;
    logic [DATA_W-1:0] req0_x2;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_x1;
    logic [DATA_W-1:0] req1_x2;

    logic              res0_valid;
    logic              res0_ready;
    logic [DATA_W-1:0] res0_y;
    logic              res0_ovf;
    logic              res1_valid;
    logic              res1_ready;
    logic [DATA_W-1:0] res1_y;
    logic              res1_ovf;

    logic [DATA_W-1:0] fm_x1;
    logic [DATA_W-1:0] fm_x2;
    logic [DATA_W-1:0] fm_y;
    logic              fm_ovf;

    modport slave (
        input  req0_valid, req0_x1, req0_x2, output req0_ready,
        input  req1_valid, req1_x1, req1_x2, output req1_ready,
        output res0_valid, res0_y, res0_ovf, input  res0_ready,
        output res1_valid, res1_y, res1_ovf, input  res1_ready,
        output fm_x1, fm_x2, input  fm_y, fm_ovf
    );

    modport master (
        output req0_valid, req0_x1, req0_x2, input  req0_ready,
        output req1_valid, req1_x1, req1_x2, input  req1_ready,
        input  res0_valid, res0_y, res0_ovf, output res0_ready,
        input  res1_valid, res1_y, res1_ovf, output res1_ready,
        input  fm_x1, fm_x2, output fm_y, fm_ovf
    );
endinterface

// File: rtl/fmul_arb.sv
// fmul_arb: shares one fixed-latency pipelined fmul between two requesters.
// Round-robin grant (at most one issue per cycle), a tag shadow pipeline that
// follows each operation through the fmul, and one show-ahead result FIFO per
// requester. Per-requester credits (in flight + buffered) stop issue before a
// FIFO could overflow, so the fmul itself never stalls.
// Ports:
//   clk  : clock
//   rst  : synchronous reset, active-high
//   bus  : fmul_arb_if.slave (req*, res*, fm_* signals)
//   busy : any operation in flight or any result buffered
module fmul_arb #(
    parameter int LAT     = 2,
    parameter int OVF_LAT = 1,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst,
    fmul_arb_if.slave    bus,
    output logic         busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] cnt [2];
    logic          last_grant;
    logic [1:0]    elig;
    logic [1:0]    grant;
    logic [1:0]    pop;
    logic [1:0]    wr;
    logic [1:0]    res_vld;

    logic          tag_vld_p [1:LAT];
    logic          tag_id_p  [1:LAT];
    logic          ovf_p     [1:LAT];
    logic          ovf_at_lat;

    logic [32:0]   mem    [2][DEPTH];
    logic [PW-1:0] wr_ptr [2];
    logic [PW-1:0] rd_ptr [2];
    logic [CW-1:0] fcnt   [2];
    logic [32:0]   head0;
    logic [32:0]   head1;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Issue stage: eligibility, round-robin grant and operand steering.
    // Eligibility uses only the registered credit count, so a same-cycle pop
    // never reaches req_ready combinationally.
    always_comb begin
        elig[0]  = bus.req0_valid && (cnt[0] < CW'(DEPTH));
        elig[1]  = bus.req1_valid && (cnt[1] < CW'(DEPTH));
        grant[0] = !rst && elig[0] && (!elig[1] || last_grant);
        grant[1] = !rst && elig[1] && (!elig[0] || !last_grant);
    end

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.fm_x1 = grant[0] ? bus.req0_x1 : (grant[1] ? bus.req1_x1 : '0);
    assign bus.fm_x2 = grant[0] ? bus.req0_x2 : (grant[1] ? bus.req1_x2 : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (grant[0]) begin
            last_grant <= 1'b0;
        end else if (grant[1]) begin
            last_grant <= 1'b1;
        end
    end

    // Tag shadow pipeline: stage k is visible k cycles after issue. Only the
    // valid bits are reset, so products still inside the fmul at reset drain
    // out with invalid tags and are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k <= LAT; k++) tag_vld_p[k] <= 1'b0;
        end else begin
            tag_vld_p[1] <= |grant;
            for (int k = 1; k < LAT; k++) tag_vld_p[k+1] <= tag_vld_p[k];
        end
    end

    // fm_ovf arrives at stage OVF_LAT; it is captured there and carried along
    // with the tag so that it lines up with fm_y at stage LAT.
    always_ff @(posedge clk) begin
        tag_id_p[1] <= grant[1];
        ovf_p[1]    <= (OVF_LAT == 0) ? bus.fm_ovf : 1'b0;
        for (int k = 1; k < LAT; k++) begin
            tag_id_p[k+1] <= tag_id_p[k];
            ovf_p[k+1]    <= (k == OVF_LAT) ? bus.fm_ovf : ovf_p[k];
        end
    end

    assign ovf_at_lat = (OVF_LAT == LAT) ? bus.fm_ovf : ovf_p[LAT];

    // Writeback stage: a valid tag at stage LAT writes {ovf, y} into its FIFO.
    assign wr[0] = tag_vld_p[LAT] && !tag_id_p[LAT];
    assign wr[1] = tag_vld_p[LAT] &&  tag_id_p[LAT];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr[i]) mem[i][wr_ptr[i]] <= {ovf_at_lat, bus.fm_y};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                fcnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (wr[i])  wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                if (wr[i] && !pop[i])      fcnt[i] <= fcnt[i] + 1'b1;
                else if (!wr[i] && pop[i]) fcnt[i] <= fcnt[i] - 1'b1;
            end
        end
    end

    // Result stage: show-ahead head, outputs forced to zero when empty.
    assign res_vld[0] = !rst && (fcnt[0] != '0);
    assign res_vld[1] = !rst && (fcnt[1] != '0);
    assign pop[0]     = res_vld[0] && bus.res0_ready;
    assign pop[1]     = res_vld[1] && bus.res1_ready;
    assign head0      = mem[0][rd_ptr[0]];
    assign head1      = mem[1][rd_ptr[1]];

    assign bus.res0_valid = res_vld[0];
    assign bus.res0_y     = res_vld[0] ? head0[31:0] : '0;
    assign bus.res0_ovf   = res_vld[0] && head0[32];
    assign bus.res1_valid = res_vld[1];
    assign bus.res1_y     = res_vld[1] ? head1[31:0] : '0;
    assign bus.res1_ovf   = res_vld[1] && head1[32];

    // Credits: in flight plus buffered results per requester.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (grant[i] && !pop[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (!grant[i] && pop[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    assign busy = !rst && ((cnt[0] != '0) || (cnt[1] != '0));
endmodule

// File: tb/tb_fmul_arb.sv
// tb_fmul_arb: directed bench for fmul_arb with a behavioural 2-stage fmul
// (product after 2 cycles, overflow flag after 1) and per-requester
// scoreboards filled on each accepted request and drained on each result pop.
module tb_fmul_arb;
    logic clk = 1'b0;
    logic rst;
    logic busy;

    always #5 clk = ~clk;

    fmul_arb_if bus ();

    fmul_arb #(.LAT(2), .OVF_LAT(1), .DEPTH(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    int errors = 0;
    int checks = 0;
    logic [32:0] q0[$];
    logic [32:0] q1[$];
    int n0, n1;
    logic acc0, acc1;

    // Reference single-precision multiply for normal operands, truncating
    // mantissa; returns {ovf, y}.
    function automatic logic [32:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        int          e;
        logic [47:0] p;
        logic [22:0] m;
        s = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {1'b0, s, 31'b0};
        p = {24'b0, 1'b1, a[22:0]} * {24'b0, 1'b1, b[22:0]};
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p[47]) begin
            m = p[46:24];
            e++;
        end else begin
            m = p[45:23];
        end
        if (e >= 255) return {1'b1, s, 8'hFF, 23'b0};
        if (e <= 0) return {1'b0, s, 31'b0};
        return {1'b0, s, e[7:0], m};
    endfunction

    // Behavioural fmul: y after 2 cycles, ovf after 1 cycle.
    logic [31:0] y_p1, y_p2;
    logic        ovf_p1;
    always @(posedge clk) begin : fm_model
        logic [32:0] r;
        r = fp_mul(bus.fm_x1, bus.fm_x2);
        y_p1   <= r[31:0];
        y_p2   <= y_p1;
        ovf_p1 <= r[32];
    end
    assign bus.fm_y   = y_p2;
    assign bus.fm_ovf = ovf_p1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accepted request, compare on result pop.
    always @(negedge clk) begin : scoreboard
        logic [32:0] e;
        if (rst) begin
            q0.delete();
            q1.delete();
        end else begin
            if (bus.req0_valid && bus.req0_ready) q0.push_back(fp_mul(bus.req0_x1, bus.req0_x2));
            if (bus.req1_valid && bus.req1_ready) q1.push_back(fp_mul(bus.req1_x1, bus.req1_x2));
            if (bus.res0_valid && bus.res0_ready) begin
                checks++;
                assert (q0.size() != 0) else begin
                    errors++;
                    $error("FAIL sb0_unexpected: observed result %h expected none", bus.res0_y);
                end
                if (q0.size() != 0) begin
                    e = q0.pop_front();
                    chk("sb0_y", bus.res0_y, e[31:0]);
                    chk("sb0_ovf", {31'b0, bus.res0_ovf}, {31'b0, e[32]});
                end
            end
            if (bus.res1_valid && bus.res1_ready) begin
                checks++;
                assert (q1.size() != 0) else begin
                    errors++;
                    $error("FAIL sb1_unexpected: observed result %h expected none", bus.res1_y);
                end
                if (q1.size() != 0) begin
                    e = q1.pop_front();
                    chk("sb1_y", bus.res1_y, e[31:0]);
                    chk("sb1_ovf", {31'b0, bus.res1_ovf}, {31'b0, e[32]});
                end
            end
        end
    end

    task automatic set_ops0();
        bus.req0_x1 = 32'h3F800000 | 32'(n0 << 12);
        bus.req0_x2 = 32'h40000000 | 32'(n0 << 6);
    endtask

    task automatic set_ops1();
        bus.req1_x1 = 32'hBF800000 | 32'(n1 << 13);
        bus.req1_x2 = 32'h3FC00000 | 32'(n1 << 5);
    endtask

    // Mid-cycle sample point; records handshakes so operands advance after them.
    task automatic mid();
        @(negedge clk);
        acc0 = bus.req0_valid && bus.req0_ready;
        acc1 = bus.req1_valid && bus.req1_ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (acc0) begin n0++; set_ops0(); end
        if (acc1) begin n1++; set_ops1(); end
        acc0 = 1'b0;
        acc1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        rst = 1'b1;
        n0 = 0; n1 = 0; acc0 = 1'b0; acc1 = 1'b0;
        set_ops0(); set_ops1();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.res0_ready = 1'b1; bus.res1_ready = 1'b1;

        // Reset: outputs quiet even with requests pending.
        repeat (2) tick();
        mid();
        chk("rst_req0_ready", {31'b0, bus.req0_ready}, 32'd0);
        chk("rst_req1_ready", {31'b0, bus.req1_ready}, 32'd0);
        chk("rst_res0_valid", {31'b0, bus.res0_valid}, 32'd0);
        chk("rst_res1_valid", {31'b0, bus.res1_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_fm_x1", bus.fm_x1, 32'd0);
        chk("rst_res0_y", bus.res0_y, 32'd0);
        tick();
        rst = 1'b0;

        // Single op: 2.0 * 3.0.
        bus.req1_valid = 1'b0;
        bus.req0_x1 = 32'h40000000; bus.req0_x2 = 32'h40400000;
        bus.req0_valid = 1'b1;
        mid();
        chk("t1_req0_ready", {31'b0, bus.req0_ready}, 32'd1);
        chk("t1_fm_x1", bus.fm_x1, 32'h40000000);
        chk("t1_fm_x2", bus.fm_x2, 32'h40400000);
        tick();
        bus.req0_valid = 1'b0;
        mid();
        chk("t1_busy_c1", {31'b0, busy}, 32'd1);
        chk("t1_fm_x1_idle", bus.fm_x1, 32'd0);
        tick(); mid();
        chk("t1_res0_valid_c2", {31'b0, bus.res0_valid}, 32'd0);
        tick(); mid();
        chk("t1_res0_valid_c3", {31'b0, bus.res0_valid}, 32'd1);
        chk("t1_res0_y", bus.res0_y, 32'h40C00000);
        chk("t1_res0_ovf", {31'b0, bus.res0_ovf}, 32'd0);
        chk("t1_busy_c3", {31'b0, busy}, 32'd1);
        tick(); mid();
        chk("t1_busy_c4", {31'b0, busy}, 32'd0);
        chk("t1_res0_valid_c4", {31'b0, bus.res0_valid}, 32'd0);
        tick();

        // Contention: req0 was granted last, so req1 wins first, then alternate.
        set_ops0(); set_ops1();
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            mid();
            chk("t2_req0_ready", {31'b0, bus.req0_ready}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t2_req1_ready", {31'b0, bus.req1_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            tick();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (5) begin mid(); tick(); end
        chk("t2_q0_drained", 32'(q0.size()), 32'd0);
        chk("t2_q1_drained", 32'(q1.size()), 32'd0);

        // Backpressure: req0 stalls after 4 credits, req1 then gets every cycle.
        bus.res0_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        a0 = 0;
        for (int k = 0; k < 14; k++) begin
            mid();
            if (acc0) a0++;
            if (k >= 8) begin
                chk("t3_req0_blocked", {31'b0, bus.req0_ready}, 32'd0);
                chk("t3_req1_granted", {31'b0, bus.req1_ready}, 32'd1);
            end
            tick();
        end
        chk("t3_accepted0", 32'(a0), 32'd4);
        bus.req1_valid = 1'b0;
        repeat (3) begin mid(); tick(); end
        mid();
        chk("t3_res0_valid_full", {31'b0, bus.res0_valid}, 32'd1);
        chk("t3_req0_ready_full", {31'b0, bus.req0_ready}, 32'd0);
        tick();

        // Full credit with a one-cycle pop: no grant in the pop cycle, grant next.
        bus.res0_ready = 1'b1;
        mid();
        chk("t6_no_grant_on_pop", {31'b0, bus.req0_ready}, 32'd0);
        tick();
        bus.res0_ready = 1'b0;
        mid();
        chk("t6_grant_after_pop", {31'b0, bus.req0_ready}, 32'd1);
        tick(); mid();
        chk("t6_full_again", {31'b0, bus.req0_ready}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        bus.res0_ready = 1'b1;
        repeat (8) begin mid(); tick(); end
        mid();
        chk("t3_busy_drained", {31'b0, busy}, 32'd0);
        chk("t3_q0_drained", 32'(q0.size()), 32'd0);
        chk("t3_q1_drained", 32'(q1.size()), 32'd0);
        tick();

        // Overflow then a benign op back-to-back: ovf must follow its product.
        bus.req0_x1 = 32'h7F000000; bus.req0_x2 = 32'h7F000000;
        bus.req0_valid = 1'b1;
        mid();
        chk("t4_ready_a", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_x1 = 32'h3F800000; bus.req0_x2 = 32'h3F800000;
        mid();
        chk("t4_ready_b", {31'b0, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        mid(); tick(); mid();
        chk("t4_y_ovf_op", bus.res0_y, 32'h7F800000);
        chk("t4_ovf_set", {31'b0, bus.res0_ovf}, 32'd1);
        tick(); mid();
        chk("t4_y_one", bus.res0_y, 32'h3F800000);
        chk("t4_ovf_clear", {31'b0, bus.res0_ovf}, 32'd0);
        tick();
        repeat (3) begin mid(); tick(); end

        // Reset mid-flight: in-flight products are dropped.
        set_ops0();
        bus.req0_valid = 1'b1;
        mid(); tick();
        mid(); tick();
        rst = 1'b1;
        mid();
        chk("t5_res0_valid_rst", {31'b0, bus.res0_valid}, 32'd0);
        chk("t5_busy_rst", {31'b0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        mid();
        chk("t5_ready_after_rst", {31'b0, bus.req0_ready}, 32'd1);
        chk("t5_busy_after_rst", {31'b0, busy}, 32'd0);
        chk("t5_res0_valid_c3", {31'b0, bus.res0_valid}, 32'd0);
        tick();
        bus.req0_valid = 1'b0;
        mid();
        chk("t5_res0_valid_c4", {31'b0, bus.res0_valid}, 32'd0);
        tick(); mid();
        chk("t5_res0_valid_c5", {31'b0, bus.res0_valid}, 32'd0);
        tick();
        repeat (6) begin mid(); tick(); end
        chk("end_q0_drained", 32'(q0.size()), 32'd0);
        chk("end_q1_drained", 32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
